frame_row_sink: RTL and testbench

FRAME_ROW_SINK -- requirements
Module: frame_row_sink

---
 rtl/frame_pkg.sv | 14 +
 rtl/row_bank_ram.sv | 37 +++
 rtl/frame_row_sink.sv | 112 +++++++++++
 tb/tb_frame_row_sink.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared row width, frame depth, row type and FSM state for frame_row_sink
package frame_pkg;
  localparam int ROW_W_DEF  = 80;
  localparam int N_ROWS_DEF = 41;
  localparam int ADDR_W     = 6;

  typedef logic [ROW_W_DEF-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2
  } state_t;
endpackage

// File: rtl/row_bank_ram.sv
// rtl/row_bank_ram.sv - two N_ROWS x ROW_W row banks, write to the hidden bank, registered read of the shown bank
module row_bank_ram
  import frame_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int N_ROWS = N_ROWS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bankSel,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [ROW_W-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [ROW_W-1:0]  rdData
);

  logic [ROW_W-1:0] mem [2][N_ROWS];

  // bankSel names the display bank; writes always land in the other one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N_ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
      rdData <= '0;
    end else begin
      if (wrEn) begin
        mem[~bankSel][wrAddr] <= wrData;
      end
      rdData <= (int'(rdAddr) < N_ROWS) ? mem[bankSel][rdAddr] : '0;
    end
  end

endmodule

// File: rtl/frame_row_sink.sv
// rtl/frame_row_sink.sv - double-buffered frame row sink; FRAME_ROW_SINK_MIRROR_EN bit-reverses rows on write
module frame_row_sink
  import frame_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int N_ROWS = N_ROWS_DEF
) (
  input  logic              cnt,
  input  logic              rst,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              row_valid,
  input  logic              row_sof,
  output logic              row_ready,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [ROW_W-1:0]  scan_row,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              resync_err
);

  state_t            state, nextState;
  logic [ADDR_W-1:0] wrIdx, nextWrIdx, wrAddr;
  logic              wrEn, setResync, bankSel, accept;
  logic [ROW_W-1:0]  wrData;

`ifdef FRAME_ROW_SINK_MIRROR_EN
  always_comb begin
    wrData = '0;
    for (int b = 0; b < ROW_W; b++) begin
      wrData[b] = row_in[ROW_W-1-b];
    end
  end
`else
  assign wrData = row_in;
`endif

  assign row_ready = (state != SWAP);
  assign accept    = row_valid && row_ready;

  always_comb begin
    nextState = state;
    nextWrIdx = wrIdx;
    wrAddr    = wrIdx;
    wrEn      = 1'b0;
    setResync = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && row_sof) begin
          wrEn      = 1'b1;
          wrAddr    = '0;
          nextWrIdx = ADDR_W'(1);
          nextState = FILL;
        end
      end
      FILL: begin
        if (accept && row_sof) begin
          // restarted frame: overwrite from row 0 and flag the lost partial
          wrEn      = 1'b1;
          wrAddr    = '0;
          nextWrIdx = ADDR_W'(1);
          setResync = 1'b1;
        end else if (accept) begin
          wrEn      = 1'b1;
          nextWrIdx = wrIdx + ADDR_W'(1);
          if (wrIdx == ADDR_W'(N_ROWS - 1)) begin
            nextWrIdx = '0;
            nextState = SWAP;
          end
        end
      end
      SWAP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge cnt or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wrIdx       <= '0;
      bankSel     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      resync_err  <= 1'b0;
    end else begin
      state      <= nextState;
      wrIdx      <= nextWrIdx;
      frame_done <= (nextState == SWAP);
      if (state == SWAP) begin
        bankSel     <= ~bankSel;
        frame_count <= frame_count + 8'd1;
      end
      if (setResync) begin
        resync_err <= 1'b1;
      end
    end
  end

  row_bank_ram #(
    .ROW_W (ROW_W),
    .N_ROWS(N_ROWS)
  ) u_bank (
    .clk    (cnt),
    .rst    (rst),
    .bankSel(bankSel),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdAddr (scan_addr),
    .rdData (scan_row)
  );

endmodule

// File: tb/tb_frame_row_sink.sv
// tb/tb_frame_row_sink.sv - directed bench for frame_row_sink with a frame-level reference model
module tb_frame_row_sink;
  logic        cnt = 1'b0;
  logic        rst;
  logic [79:0] row_in;
  logic        row_valid, row_sof, row_ready;
  logic [5:0]  scan_addr;
  logic [79:0] scan_row;
  logic        frame_done, resync_err;
  logic [7:0]  frame_count;

  int compared = 0;
  int mismatched = 0;

  frame_row_sink dut (
    .cnt        (cnt),
    .rst        (rst),
    .row_in     (row_in),
    .row_valid  (row_valid),
    .row_sof    (row_sof),
    .row_ready  (row_ready),
    .scan_addr  (scan_addr),
    .scan_row   (scan_row),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .resync_err (resync_err)
  );

  always #5 cnt = ~cnt;

  // frame-level model: a shown frame, a frame being assembled, and a pending swap
  logic [79:0] shown [41];
  logic [79:0] building [41];
  int          mCount;
  bit          mResync, mSwap, mFilling;
  int          mNext;
  logic [79:0] mScan;

  function automatic logic [79:0] stored(input logic [79:0] r);
    logic [79:0] o;
`ifdef FRAME_ROW_SINK_MIRROR_EN
    for (int b = 0; b < 80; b++) o[b] = r[79-b];
`else
    o = r;
`endif
    return o;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 41; i++) begin
      shown[i] = '0;
      building[i] = '0;
    end
    mCount = 0; mResync = 0; mSwap = 0; mFilling = 0; mNext = 0; mScan = '0;
  endtask

  task automatic modelEdge();
    logic [79:0] t;
    mScan = (scan_addr < 41) ? shown[scan_addr] : '0;
    if (mSwap) begin
      for (int i = 0; i < 41; i++) begin
        t = shown[i]; shown[i] = building[i]; building[i] = t;
      end
      mCount = mCount + 1;
      mSwap = 0;
    end else if (row_valid) begin
      if (row_sof) begin
        if (mFilling) mResync = 1;
        building[0] = stored(row_in);
        mFilling = 1;
        mNext = 1;
      end else if (mFilling) begin
        building[mNext] = stored(row_in);
        mNext = mNext + 1;
        if (mNext == 41) begin
          mFilling = 0;
          mSwap = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge cnt) begin
    chk("row_ready", 80'(row_ready), 80'(!mSwap));
    chk("frame_done", 80'(frame_done), 80'(mSwap));
    chk("frame_count", 80'(frame_count), 80'(mCount[7:0]));
    chk("resync_err", 80'(resync_err), 80'(mResync));
    chk("scan_row", scan_row, mScan);
  end

  task automatic step(input logic v, input logic s, input logic [79:0] r, input logic [5:0] a);
    row_valid = v; row_sof = s; row_in = r; scan_addr = a;
    @(posedge cnt);
    modelEdge();
    #1;
  endtask

  task automatic pulseReset();
    #1;
    rst = 1'b1;
    modelReset();
    @(posedge cnt);
    #1;
    rst = 1'b0;
  endtask

  task automatic sendFrame(input int base, input logic [79:0] first);
    for (int i = 0; i < 41; i++)
      step(1'b1, i == 0, (i == 0) ? first : 80'(base + i), 6'(i));
  endtask

  logic [79:0] e7, e777, e1;

  initial begin
    rst = 1'b1; row_valid = 0; row_sof = 0; row_in = '0; scan_addr = '0;
    modelReset();
`ifdef FRAME_ROW_SINK_MIRROR_EN
    e7   = 80'hE000_0000_0000_0000_0000;
    e1   = 80'h8000_0000_0000_0000_0000;
`else
    e7   = 80'h7;
    e1   = 80'h1;
`endif
    e777 = stored(80'd777);
    repeat (2) @(posedge cnt);
    #1;
    rst = 1'b0;
    chk("lit_reset_count", 80'(frame_count), 80'd0);
    chk("lit_reset_ready", 80'(row_ready), 80'd1);
    chk("lit_reset_scan", scan_row, 80'd0);

    // rows without sof from idle are dropped
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 80'(50 + i), 6'(i));
    chk("lit_nosof_count", 80'(frame_count), 80'd0);
    chk("lit_nosof_scan", scan_row, 80'd0);

    // first full frame, row_in = index
    sendFrame(0, 80'd0);
    chk("lit_done_pulse", 80'(frame_done), 80'd1);
    chk("lit_swap_ready", 80'(row_ready), 80'd0);
    step(1'b0, 1'b0, '0, 6'd7);
    chk("lit_done_clear", 80'(frame_done), 80'd0);
    step(1'b0, 1'b0, '0, 6'd7);
    chk("lit_scan7", scan_row, e7);
    chk("lit_count1", 80'(frame_count), 80'd1);

    // frame 2 with row_valid held through SWAP, then a new sof frame
    sendFrame(100, 80'd100);
    chk("lit_swap_ready2", 80'(row_ready), 80'd0);
    step(1'b1, 1'b0, 80'd999, 6'd3);
    step(1'b1, 1'b1, 80'd555, 6'd3);
    chk("lit_frame2_row3", scan_row, stored(80'd103));
    for (int i = 1; i < 20; i++) step(1'b1, 1'b0, 80'(600 + i), 6'(i));
    chk("lit_no_resync_yet", 80'(resync_err), 80'd0);
    sendFrame(700, 80'd777);
    chk("lit_resync", 80'(resync_err), 80'd1);
    step(1'b0, 1'b0, '0, 6'd0);
    step(1'b0, 1'b0, '0, 6'd0);
    chk("lit_resync_row0", scan_row, e777);
    chk("lit_count3", 80'(frame_count), 80'd3);

    // out-of-range reads
    step(1'b0, 1'b0, '0, 6'd41);
    chk("lit_scan41", scan_row, 80'd0);
    step(1'b0, 1'b0, '0, 6'd63);
    chk("lit_scan63", scan_row, 80'd0);
    step(1'b0, 1'b0, '0, 6'd40);
    chk("lit_scan40", scan_row, stored(80'd740));

    // reset in the middle of a fill
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, 80'(300 + i), 6'(i));
    pulseReset();
    chk("lit_midrst_count", 80'(frame_count), 80'd0);
    chk("lit_midrst_resync", 80'(resync_err), 80'd0);
    chk("lit_midrst_ready", 80'(row_ready), 80'd1);
    step(1'b0, 1'b0, '0, 6'd0);
    chk("lit_midrst_scan0", scan_row, 80'd0);

    // storage orientation of a single set bit
    sendFrame(0, 80'h1);
    step(1'b0, 1'b0, '0, 6'd0);
    step(1'b0, 1'b0, '0, 6'd0);
    chk("lit_mirror", scan_row, e1);

    repeat (3) step(1'b0, 1'b0, '0, 6'd0);
    @(negedge cnt);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
